ascii_msg_receiver: RTL and testbench
=====================================

// Module: ascii_msg_receiver
// PURPOSE
//  Receive-side checker for the looping ASCII message stream our character sequencer drives onto uo_out.
//  Samples one byte per rx_valid cycle and tracks position within the expected message.
//   Message A: "Guatemala" = 47 75 61 74 65 6D 61 6C 61.
//   Message B: "QQuetza"   = 51 51 75 65 74 7A 61.
//  Message is selected by mode. Reports lock status, message completions and framing errors.
//  Sits on the loopback/test path after the sequencer; feeds status to debug outputs.
// PARAMETERS
//  CNT_W  8  width of msg_count and err_count (saturating counters)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      reset, asynchronous, active-high (rst_n=1 resets)
//  mode       in   2      00/11 -> expect message A (len 9); 01/10 -> expect message B (len 7)
//  rx_data    in   8      received ASCII byte
//  rx_valid   in   1      rx_data valid this cycle; no backpressure
//  locked     out  1      1 = full message matched and stream still in sequence
//  msg_done   out  1      1-cycle pulse: last byte of a message accepted
//  char_idx   out  4      number of message bytes currently matched (0..len-1)
//  msg_count  out  CNT_W  completed messages, saturates at all-ones
//  err_count  out  CNT_W  sequence breaks while locked, saturates at all-ones
// BEHAVIOUR
//  Reset: reset rst_n, asynchronous, active-high; clock clk.
//   While rst_n=1, all outputs and all state are 0: state=HUNT, mode_q=class(mode).
//  Mode class is registered in mode_q: A for 00/11, B for 01/10.
//   If class(mode) != mode_q: state=HUNT, char_idx=0, locked=0, mode_q updated.
//   The byte presented in that cycle is dropped. Mode change has priority over rx_valid.
//   Counters are not cleared by a mode change.
//  rx_valid=0: all state holds; msg_done=0.
//  States: HUNT (searching) and SYNC (locked=1). Sampling is rx_valid=1 with no mode change.
//  Match (rx_data == MSG[char_idx]):
//   - If char_idx < len-1: char_idx+1.
//   - Else: char_idx=0, msg_done=1 next cycle, msg_count+1 (saturating), state=SYNC.
//  Mismatch, restart rule (prefix-aware):
//   - B with char_idx==2 and rx_data==51: char_idx stays 2.
//   - Otherwise, if rx_data==MSG[0] (47 for A, 51 for B): char_idx=1.
//   - Otherwise: char_idx=0.
//  Mismatch in SYNC: err_count+1 (saturating), locked=0, state=HUNT. The restart rule still applies.
//  Mismatch in HUNT: no count change.
//  SYNC expects back-to-back messages: after the last byte, the next sampled byte must be MSG[0].
//  All outputs registered. msg_done/locked/counters update on the edge after the sampling edge.
//   Example: the final-byte edge is followed by msg_done=1 for exactly one cycle.
//  Saturated counters hold at all-ones; no wrap.
//  Reset mid-message: immediate clear; the next message must arrive complete to lock.
// TESTING
//  T1 reset: stream mid-message, raise rst_n for 1 cycle -> all outputs 0 immediately; char_idx=0 after release.
//  T2 A lock: mode=00, 47 75 61 74 65 6D 61 6C 61 every cycle
//     -> msg_done one cycle after 61 (final byte); locked=1; msg_count=1; char_idx=0.
//  T3 B overlap: mode=01, send 51 51 51 75 65 74 7A 61 -> exactly one msg_done; msg_count=1; err_count=0.
//  T4 break: locked on A, send 47 75 78 -> err_count=1, locked=0, char_idx=0.
//     Then send a full A -> locked=1.
//  T5 gaps/mode: A with rx_valid=0 gaps between bytes -> msg_done still asserted.
//     mode 00->10 after 4 bytes -> char_idx=0, locked=0, counters unchanged.
//  T6 saturation: CNT_W=8, send 300 A messages -> msg_count=255 held; err_count=0.

Source files
------------

// File: rtl/ascii_msg_receiver.sv
// Checks a looping ASCII message stream ("Guatemala" or "QQuetza" by mode), one byte per rx_valid cycle.
// Status is registered: results appear the cycle after the sampling edge. There is no backpressure.
module ascii_msg_receiver #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             locked,
    output logic             msg_done,
    output logic [3:0]       char_idx,
    output logic [CNT_W-1:0] msg_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_mode_q;
    logic             r_mode_init;
    logic             w_mode_q_nxt;
    logic             w_mode_cls;
    logic             w_mode_eff;
    logic [3:0]       r_idx;
    logic [3:0]       w_idx_nxt;
    logic [3:0]       w_idx_last;
    logic             r_done;
    logic             w_done_nxt;
    logic [CNT_W-1:0] r_msg_cnt;
    logic [CNT_W-1:0] w_msg_cnt_nxt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] w_err_cnt_nxt;
    logic [7:0]       w_exp_byte;
    logic [7:0]       w_first_byte;

    // Message ROM: is_b selects "QQuetza", otherwise "Guatemala".
    function automatic logic [7:0] msg_byte(input logic is_b, input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (is_b) begin
            case (idx)
                4'd0:    b = 8'h51;
                4'd1:    b = 8'h51;
                4'd2:    b = 8'h75;
                4'd3:    b = 8'h65;
                4'd4:    b = 8'h74;
                4'd5:    b = 8'h7A;
                4'd6:    b = 8'h61;
                default: b = 8'h00;
            endcase
        end else begin
            case (idx)
                4'd0:    b = 8'h47;
                4'd1:    b = 8'h75;
                4'd2:    b = 8'h61;
                4'd3:    b = 8'h74;
                4'd4:    b = 8'h65;
                4'd5:    b = 8'h6D;
                4'd6:    b = 8'h61;
                4'd7:    b = 8'h6C;
                4'd8:    b = 8'h61;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    // Class 1 = message B (modes 01/10). Until the first post-reset edge the live
    // mode stands in for mode_q, so the register never needs a data-dependent reset value.
    assign w_mode_cls   = mode[1] ^ mode[0];
    assign w_mode_eff   = r_mode_init ? r_mode_q : w_mode_cls;
    assign w_idx_last   = w_mode_eff ? 4'd6 : 4'd8;
    assign w_exp_byte   = msg_byte(w_mode_eff, r_idx);
    assign w_first_byte = msg_byte(w_mode_eff, 4'd0);

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_done_nxt    = 1'b0;
        w_msg_cnt_nxt = r_msg_cnt;
        w_err_cnt_nxt = r_err_cnt;
        w_mode_q_nxt  = w_mode_eff;
        if (w_mode_cls != w_mode_eff) begin
            w_state_nxt  = HUNT;
            w_idx_nxt    = 4'd0;
            w_mode_q_nxt = w_mode_cls;
        end else if (rx_valid) begin
            if (rx_data == w_exp_byte) begin
                if (r_idx == w_idx_last) begin
                    w_idx_nxt     = 4'd0;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = SYNC;
                    w_msg_cnt_nxt = (r_msg_cnt == CNT_MAX) ? r_msg_cnt : r_msg_cnt + CNT_ONE;
                end else begin
                    w_idx_nxt = r_idx + 4'd1;
                end
            end else begin
                // "QQQ" still ends in the "QQ" prefix, so B keeps its two matched bytes.
                if (w_mode_eff && (r_idx == 4'd2) && (rx_data == 8'h51)) begin
                    w_idx_nxt = 4'd2;
                end else if (rx_data == w_first_byte) begin
                    w_idx_nxt = 4'd1;
                end else begin
                    w_idx_nxt = 4'd0;
                end
                if (r_state == SYNC) begin
                    w_state_nxt   = HUNT;
                    w_err_cnt_nxt = (r_err_cnt == CNT_MAX) ? r_err_cnt : r_err_cnt + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= HUNT;
            r_idx       <= 4'd0;
            r_done      <= 1'b0;
            r_msg_cnt   <= '0;
            r_err_cnt   <= '0;
            r_mode_q    <= 1'b0;
            r_mode_init <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_done      <= w_done_nxt;
            r_msg_cnt   <= w_msg_cnt_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_mode_q    <= w_mode_q_nxt;
            r_mode_init <= 1'b1;
        end
    end

    assign locked    = (r_state == SYNC);
    assign msg_done  = r_done;
    assign char_idx  = r_idx;
    assign msg_count = r_msg_cnt;
    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_ascii_msg_receiver.sv
// Directed bench for ascii_msg_receiver: a vector table for the streaming cases
// plus hand sequences for gaps, mode change, mid-message reset and saturation.
module tb_ascii_msg_receiver;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       locked;
    logic       msg_done;
    logic [3:0] char_idx;
    logic [7:0] msg_count;
    logic [7:0] err_count;

    int total;
    int bad;

    ascii_msg_receiver #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .locked    (locked),
        .msg_done  (msg_done),
        .char_idx  (char_idx),
        .msg_count (msg_count),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] md;
        logic       vld;
        logic [7:0] dat;
        logic       lk;
        logic       dn;
        logic [3:0] idx;
        logic [7:0] mc;
        logic [7:0] ec;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] msg_a[9];
    logic [7:0] msg_b[7];
    logic [7:0] b_olap[8];
    logic [3:0] b_olap_idx[8];

    task automatic add(input logic [1:0] md, input logic vld, input logic [7:0] dat,
                       input logic lk, input logic dn, input logic [3:0] idx,
                       input logic [7:0] mc, input logic [7:0] ec);
        vec_t v;
        v.md = md; v.vld = vld; v.dat = dat;
        v.lk = lk; v.dn = dn; v.idx = idx; v.mc = mc; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] md, input logic vld, input logic [7:0] dat);
        mode     = md;
        rx_valid = vld;
        rx_data  = dat;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic lk, input logic dn, input logic [3:0] idx,
                           input logic [7:0] mc, input logic [7:0] ec);
        chk({tag, "_locked"}, 32'(locked), 32'(lk));
        chk({tag, "_done"}, 32'(msg_done), 32'(dn));
        chk({tag, "_idx"}, 32'(char_idx), 32'(idx));
        chk({tag, "_msgcnt"}, 32'(msg_count), 32'(mc));
        chk({tag, "_errcnt"}, 32'(err_count), 32'(ec));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        msg_a = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61};
        msg_b = '{8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61};
        b_olap     = '{8'h51, 8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61};
        b_olap_idx = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0};

        // A lock from reset, then an idle cycle
        for (int k = 0; k < 9; k++)
            add(2'd0, 1'b1, msg_a[k], k == 8, k == 8, (k == 8) ? 4'd0 : 4'(k + 1), (k == 8) ? 8'd1 : 8'd0, 8'd0);
        add(2'd0, 1'b0, 8'h47, 1'b1, 1'b0, 4'd0, 8'd1, 8'd0);
        // break while locked, then relock
        add(2'd0, 1'b1, 8'h47, 1'b1, 1'b0, 4'd1, 8'd1, 8'd0);
        add(2'd0, 1'b1, 8'h75, 1'b1, 1'b0, 4'd2, 8'd1, 8'd0);
        add(2'd0, 1'b1, 8'h78, 1'b0, 1'b0, 4'd0, 8'd1, 8'd1);
        for (int k = 0; k < 9; k++)
            add(2'd0, 1'b1, msg_a[k], k == 8, k == 8, (k == 8) ? 4'd0 : 4'(k + 1), (k == 8) ? 8'd2 : 8'd1, 8'd1);
        // back-to-back message keeps lock
        for (int k = 0; k < 9; k++)
            add(2'd0, 1'b1, msg_a[k], 1'b1, k == 8, (k == 8) ? 4'd0 : 4'(k + 1), (k == 8) ? 8'd3 : 8'd2, 8'd1);
        // repeated 'G' in SYNC: error, but restart to idx 1
        add(2'd0, 1'b1, 8'h47, 1'b1, 1'b0, 4'd1, 8'd3, 8'd1);
        add(2'd0, 1'b1, 8'h47, 1'b0, 1'b0, 4'd1, 8'd3, 8'd2);
        for (int k = 1; k < 9; k++)
            add(2'd0, 1'b1, msg_a[k], k == 8, k == 8, (k == 8) ? 4'd0 : 4'(k + 1), (k == 8) ? 8'd4 : 8'd3, 8'd2);
        // switch to B: byte dropped, lock lost, counters kept
        add(2'd1, 1'b1, 8'h51, 1'b0, 1'b0, 4'd0, 8'd4, 8'd2);
        for (int k = 0; k < 8; k++)
            add(2'd1, 1'b1, b_olap[k], k == 7, k == 7, b_olap_idx[k], (k == 7) ? 8'd5 : 8'd4, 8'd2);
        add(2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 8'd5, 8'd2);
        // 01 -> 10 is the same class: no mode change
        add(2'd2, 1'b1, 8'h51, 1'b1, 1'b0, 4'd1, 8'd5, 8'd2);
        // 10 -> 11 is class A: dropped byte
        add(2'd3, 1'b1, 8'h47, 1'b0, 1'b0, 4'd0, 8'd5, 8'd2);

        mode     = 2'd0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst_n    = 1'b1;
        #2;
        chk_all("reset", 1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
        #10;
        rst_n = 1'b0;
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].md, vecs[i].vld, vecs[i].dat);
            chk_all($sformatf("v%0d", i), vecs[i].lk, vecs[i].dn, vecs[i].idx, vecs[i].mc, vecs[i].ec);
        end

        // A with idle gaps; data on idle cycles must be ignored
        for (int k = 0; k < 9; k++) begin
            step(2'd0, 1'b1, msg_a[k]);
            if (k == 8)
                chk_all("gap_last", 1'b1, 1'b1, 4'd0, 8'd6, 8'd2);
            step(2'd0, 1'b0, 8'h61);
            chk($sformatf("gap%0d_idx", k), 32'(char_idx), (k == 8) ? 32'd0 : 32'(k + 1));
        end
        chk("gap_done_clr", 32'(msg_done), 32'd0);

        // mode 00 -> 10 after 4 bytes
        for (int k = 0; k < 4; k++)
            step(2'd0, 1'b1, msg_a[k]);
        chk_all("pre_mode", 1'b1, 1'b0, 4'd4, 8'd6, 8'd2);
        step(2'd2, 1'b1, 8'h65);
        chk_all("mode_chg", 1'b0, 1'b0, 4'd0, 8'd6, 8'd2);

        // mid-message asynchronous reset
        step(2'd2, 1'b1, 8'h51);
        step(2'd2, 1'b1, 8'h51);
        chk("pre_rst_idx", 32'(char_idx), 32'd2);
        #2;
        rst_n = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        step(2'd2, 1'b0, 8'h00);
        chk("post_rst_idx", 32'(char_idx), 32'd0);
        // first byte after reset must be sampled in mode B, not dropped
        for (int k = 0; k < 7; k++) begin
            step(2'd2, 1'b1, msg_b[k]);
            if (k == 0)
                chk("post_rst_first", 32'(char_idx), 32'd1);
        end
        chk_all("post_rst_lock", 1'b1, 1'b1, 4'd0, 8'd1, 8'd0);

        // saturation: 300 A messages on top of msg_count=1
        step(2'd0, 1'b0, 8'h00);
        for (int n = 1; n <= 300; n++) begin
            for (int k = 0; k < 9; k++)
                step(2'd0, 1'b1, msg_a[k]);
            if (n == 253)
                chk("sat_minus1", 32'(msg_count), 32'd254);
            if (n == 254)
                chk("sat_hit", 32'(msg_count), 32'd255);
        end
        chk_all("sat_end", 1'b1, 1'b1, 4'd0, 8'd255, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
